// File: rtl/uart_rx_deframer.sv
// UART receive deframer: 16x oversampled start/8 data/optional parity/stop, with parity and framing flags.
// Define UART_RX_SYNC_EN to pass RxIn through a 2-flop synchronizer before sampling.
module uart_rx_deframer (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       RxIn,
    input  logic       BaudTick16,
    input  logic [1:0] ParityType,
    output logic [7:0] DataOut,
    output logic       DataValid,
    output logic       ParityError,
    output logic       FrameError,
    output logic       Busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic [7:0]  shift_d;
    logic [1:0]  ptype_q;
    logic        par_err_q;
    logic        par_err_d;
    logic        par_en;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        perr_q;
    logic        ferr_q;
    logic        rx_s;

`ifdef UART_RX_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= RxIn;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;
`else
    assign rx_s = RxIn;
`endif

    // Types 01 and 10 carry a parity bit; ptype_q[1] is then the XOR value that flags an error.
    assign par_en    = ptype_q[0] ^ ptype_q[1];
    assign cnt_d     = cnt_q + 4'd1;
    assign shift_d   = {rx_s, shift_q[7:1]};
    assign par_err_d = ((^shift_q) ^ rx_s) == ptype_q[1];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            ptype_q   <= '0;
            par_err_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (BaudTick16) begin
                case (state_q)
                    IDLE: begin
                        if (!rx_s) begin
                            state_q   <= START;
                            cnt_q     <= '0;
                            ptype_q   <= ParityType;
                            par_err_q <= 1'b0;
                        end
                    end
                    START: begin
                        if (cnt_q == 4'd7) begin
                            cnt_q     <= '0;
                            bit_idx_q <= '0;
                            state_q   <= rx_s ? IDLE : DATA;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    DATA: begin
                        cnt_q <= cnt_d;
                        if (cnt_q == 4'd15) begin
                            shift_q   <= shift_d;
                            bit_idx_q <= bit_idx_q + 3'd1;
                            if (bit_idx_q == 3'd7) begin
                                state_q <= par_en ? PARITY : STOP;
                            end
                        end
                    end
                    PARITY: begin
                        cnt_q <= cnt_d;
                        if (cnt_q == 4'd15) begin
                            par_err_q <= par_err_d;
                            state_q   <= STOP;
                        end
                    end
                    STOP: begin
                        cnt_q <= cnt_d;
                        if (cnt_q == 4'd15) begin
                            data_q  <= shift_q;
                            perr_q  <= par_en & par_err_q;
                            ferr_q  <= ~rx_s;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign DataOut     = data_q;
    assign DataValid   = valid_q;
    assign ParityError = perr_q;
    assign FrameError  = ferr_q;
    assign Busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer: directed frames push expected bytes, a monitor checks each DataValid.
module tb_uart_rx_deframer;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       RxIn;
    logic       BaudTick16;
    logic [1:0] ParityType;
    logic [7:0] DataOut;
    logic       DataValid;
    logic       ParityError;
    logic       FrameError;
    logic       Busy;

`ifdef UART_RX_SYNC_EN
    localparam int EXP_LAT = 155;
`else
    localparam int EXP_LAT = 153;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_dv_cyc = 0;
    int          start_cyc = 0;
    int unsigned tick_div = 1;
    int unsigned tphase = 0;

    uart_rx_deframer dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .RxIn       (RxIn),
        .BaudTick16 (BaudTick16),
        .ParityType (ParityType),
        .DataOut    (DataOut),
        .DataValid  (DataValid),
        .ParityError(ParityError),
        .FrameError (FrameError),
        .Busy       (Busy)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        RxIn = v;
        wait_cyc(16 * int'(tick_div));
    endtask

    task automatic send_frame(input logic [7:0] d, input bit has_par, input bit pbit, input bit stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (has_par) drive_bit(pbit);
        drive_bit(stop);
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d;
        e.perr = pe;
        e.ferr = fe;
        exp_q.push_back(e);
    endtask

    // Tick generator: every cycle, or one in tick_div cycles.
    initial begin
        BaudTick16 = 1'b1;
        forever begin
            @(posedge Clock);
            #1;
            if (tick_div <= 1) begin
                BaudTick16 = 1'b1;
            end else begin
                tphase     = (tphase + 1) % tick_div;
                BaudTick16 = (tphase == 0);
            end
        end
    end

    // Monitor: every DataValid cycle consumes one expected frame.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (DataValid === 1'b1) begin
                last_dv_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid actual=1 required=0 data=%0h (t=%0t)", DataOut, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("data_out", DataOut, e.data);
                    check("parity_error", ParityError, e.perr);
                    check("frame_error", FrameError, e.ferr);
                end
            end
        end
    end

    initial begin
        Reset      = 1'b1;
        RxIn       = 1'b1;
        ParityType = 2'b00;
        wait_cyc(3);
        check("rst_data", DataOut, 8'h00);
        check("rst_valid", DataValid, 1'b0);
        check("rst_perr", ParityError, 1'b0);
        check("rst_ferr", FrameError, 1'b0);
        check("rst_busy", Busy, 1'b0);
        Reset = 1'b0;
        wait_cyc(5);
        check("idle_ticks_busy", Busy, 1'b0);

        // No parity 0xA5 with latency and Busy checks
        expect_frame(8'hA5, 1'b0, 1'b0);
        start_cyc = cyc;
        fork
            send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
            begin
                wait_cyc(4);
                check("busy_in_frame", Busy, 1'b1);
            end
        join
        check("latency_no_parity", last_dv_cyc - start_cyc, EXP_LAT);
        check("busy_after_frame", Busy, 1'b0);

        // Type 11 behaves as no parity
        ParityType = 2'b11;
        expect_frame(8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);

        // Odd parity: 0x07 has three ones
        ParityType = 2'b01;
        expect_frame(8'h07, 1'b0, 1'b0);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        expect_frame(8'h07, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);

        // Even parity, then a framing error frame
        ParityType = 2'b10;
        expect_frame(8'h03, 1'b0, 1'b0);
        send_frame(8'h03, 1'b1, 1'b0, 1'b1);
        expect_frame(8'hFF, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        RxIn = 1'b1;
        wait_cyc(40);

        // False start: low for 4 ticks only
        RxIn = 1'b0;
        wait_cyc(4);
        RxIn = 1'b1;
        wait_cyc(2);
        check("false_start_busy", Busy, 1'b1);
        wait_cyc(6);
        check("false_start_idle", Busy, 1'b0);
        wait_cyc(20);
        check("false_start_data", DataOut, 8'hFF);
        check("false_start_ferr", FrameError, 1'b1);
        check("false_start_perr", ParityError, 1'b0);

        // Slower tick: one tick every third cycle
        ParityType = 2'b00;
        tick_div   = 3;
        expect_frame(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        wait_cyc(10);
        tick_div = 1;
        wait_cyc(5);

        // Reset during data bit 4 of 0x3C, then a clean 0x81
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        RxIn = 1'b1;
        wait_cyc(8);
        Reset = 1'b1;
        wait_cyc(1);
        check("midrst_data", DataOut, 8'h00);
        check("midrst_valid", DataValid, 1'b0);
        check("midrst_perr", ParityError, 1'b0);
        check("midrst_ferr", FrameError, 1'b0);
        check("midrst_busy", Busy, 1'b0);
        wait_cyc(1);
        Reset = 1'b0;
        wait_cyc(40);
        expect_frame(8'h81, 1'b0, 1'b0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);

        // Parity type changed mid-frame, two frames back to back
        ParityType = 2'b01;
        expect_frame(8'h55, 1'b1, 1'b0);
        expect_frame(8'h0F, 1'b0, 1'b0);
        fork
            begin
                send_frame(8'h55, 1'b1, 1'b0, 1'b1);
                send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
            end
            begin
                wait_cyc(40);
                ParityType = 2'b00;
            end
        join
        RxIn = 1'b1;

        for (int i = 0; i < 500; i++) begin
            if (exp_q.size() == 0) break;
            wait_cyc(1);
        end
        wait_cyc(20);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
